// File: rtl/tdm_demux_pkg.sv
// rtl/tdm_demux_pkg.sv - shared types, slot codes and sizing helper for tdm_demux4
package tdm_demux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] SLOT_A = 2'b00;
    localparam logic [1:0] SLOT_B = 2'b01;
    localparam logic [1:0] SLOT_C = 2'b10;
    localparam logic [1:0] SLOT_D = 2'b11;

    // Beat counter width: ceil(log2(hold)), never less than one bit.
    function automatic int beat_width(input int hold);
        if (hold <= 2) begin
            return 1;
        end
        return $clog2(hold);
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - beat and slot counters that regenerate the {S,T} sweep
module tdm_slot_counter
    import tdm_demux_pkg::*;
#(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    input  logic       restart,
    output logic [1:0] slot,
    output logic       last_beat,
    output logic       frame_done,
    output logic       at_start
);

    localparam int             BW        = beat_width(HOLD);
    localparam logic [BW-1:0]  LAST_BEAT = BW'(HOLD - 1);

    logic [BW-1:0] r_beat;
    logic [1:0]    r_slot;
    logic [BW-1:0] w_beat;
    logic [1:0]    w_slot;

    // A restart makes the present beat count as beat 0 of slot A.
    assign w_beat     = restart ? '0 : r_beat;
    assign w_slot     = restart ? SLOT_A : r_slot;
    assign last_beat  = advance && (w_beat == LAST_BEAT);
    assign frame_done = last_beat && (w_slot == SLOT_D);
    assign at_start   = (r_beat == '0) && (r_slot == SLOT_A);
    assign slot       = r_slot;

    // Step the beat counter on each accepted beat; roll into the next slot on the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat <= '0;
            r_slot <= SLOT_A;
        end else if (advance) begin
            if (last_beat) begin
                r_beat <= '0;
                r_slot <= w_slot + 2'd1;
            end else begin
                r_beat <= w_beat + 1'b1;
                r_slot <= w_slot;
            end
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - four-channel TDM receiver; optional resync checking via TDM_DEMUX4_SYNC_CHECK_EN
module tdm_demux4
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync_i,
    output logic [WIDTH-1:0] ch_a,
    output logic [WIDTH-1:0] ch_b,
    output logic [WIDTH-1:0] ch_c,
    output logic [WIDTH-1:0] ch_d,
    output logic             frame_valid,
    output logic             sel_s,
    output logic             sel_t,
    output logic             locked,
    output logic             sync_err
);

    state_t           r_state;
    logic [WIDTH-1:0] r_cap_a;
    logic [WIDTH-1:0] r_cap_b;
    logic [WIDTH-1:0] r_cap_c;
    logic [WIDTH-1:0] r_ch_a;
    logic [WIDTH-1:0] r_ch_b;
    logic [WIDTH-1:0] r_ch_c;
    logic [WIDTH-1:0] r_ch_d;
    logic             r_frame_valid;

    logic       w_sync_beat;
    logic       w_resync;
    logic       w_restart;
    logic       w_advance;
    logic [1:0] w_slot;
    logic [1:0] w_cur_slot;
    logic       w_last_beat;
    logic       w_frame_done;
    logic       w_at_start;

    assign w_sync_beat = din_valid && sync_i;

`ifdef TDM_DEMUX4_SYNC_CHECK_EN
    // Sync anywhere but the start of slot A means the transmitter and we disagree.
    assign w_resync = w_sync_beat && (r_state == RUN) && !w_at_start;
`else
    assign w_resync = 1'b0;
`endif

    // Restarting on an on-time sync is identical to a normal advance, so it is harmless.
    assign w_restart  = w_sync_beat && ((r_state == IDLE) || w_at_start || w_resync);
    assign w_advance  = din_valid && ((r_state == RUN) || w_restart);
    assign w_cur_slot = w_restart ? SLOT_A : w_slot;

    tdm_slot_counter #(
        .HOLD (HOLD)
    ) u_slot_counter (
        .clk        (clk),
        .rst        (rst),
        .advance    (w_advance),
        .restart    (w_restart),
        .slot       (w_slot),
        .last_beat  (w_last_beat),
        .frame_done (w_frame_done),
        .at_start   (w_at_start)
    );

    // Lock on the first qualified sync; only reset returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (w_restart) begin
            r_state <= RUN;
        end
    end

    // Capture each slot's sample on its last beat; slot D bypasses straight to the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_a <= '0;
            r_cap_b <= '0;
            r_cap_c <= '0;
        end else begin
            if (w_resync) begin
                r_cap_a <= '0;
                r_cap_b <= '0;
                r_cap_c <= '0;
            end
            if (w_last_beat) begin
                case (w_cur_slot)
                    SLOT_A:  r_cap_a <= din;
                    SLOT_B:  r_cap_b <= din;
                    SLOT_C:  r_cap_c <= din;
                    default: ;
                endcase
            end
        end
    end

    // Publish a complete frame atomically, one cycle after the slot D capture beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch_a        <= '0;
            r_ch_b        <= '0;
            r_ch_c        <= '0;
            r_ch_d        <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= w_frame_done;
            if (w_frame_done) begin
                r_ch_a <= r_cap_a;
                r_ch_b <= r_cap_b;
                r_ch_c <= r_cap_c;
                r_ch_d <= din;
            end
        end
    end

`ifdef TDM_DEMUX4_SYNC_CHECK_EN
    logic r_sync_err;

    // Flag every resync for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= w_resync;
        end
    end

    assign sync_err = r_sync_err;
`else
    assign sync_err = 1'b0;
`endif

    assign ch_a        = r_ch_a;
    assign ch_b        = r_ch_b;
    assign ch_c        = r_ch_c;
    assign ch_d        = r_ch_d;
    assign frame_valid = r_frame_valid;
    assign sel_s       = w_slot[1];
    assign sel_t       = w_slot[0];
    assign locked      = (r_state == RUN);

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receiving end of the four-channel select-swept link.
- A 4:1 mux transmitter serialises channels A–D onto one line. The select pair {S,T} sweeps 00→01→10→11, and each slot is held for a fixed number of beats.
- This block regenerates the slot sequence, captures each channel's sample and delivers complete 4-channel frames with a one-cycle valid strobe.
- Sits between the serial line and the downstream frame consumer.

Parameters:
- WIDTH, 1: bits per channel sample (din and each ch_* output).
- HOLD, 4: valid beats per slot, range 1..256. The sample is taken on the last beat of the slot.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  WIDTH  serial channel data.
- din_valid  in  1  din carries a beat this cycle.
- sync_i  in  1  qualified by din_valid. Marks the first beat of slot A (S=0, T=0).
- ch_a  out  WIDTH  last complete frame, slot {S,T}=00.
- ch_b  out  WIDTH  slot 01.
- ch_c  out  WIDTH  slot 10.
- ch_d  out  WIDTH  slot 11.
- frame_valid  out  1  one-cycle pulse when ch_a..ch_d update.
- sel_s  out  1  regenerated S (slot MSB) for the current slot.
- sel_t  out  1  regenerated T (slot LSB).
- locked  out  1  high while in RUN.
- sync_err  out  1  one-cycle pulse on a mid-frame sync (feature only).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; slot=00; beat counter=0.
  - Capture registers, ch_a..ch_d, frame_valid, locked, sync_err all 0.
  - Reset mid-frame discards the partial frame; no frame_valid is produced for it.
- Only beats with din_valid=1 advance anything. When din_valid=0, all state holds.
- IDLE:
  - Waits for din_valid & sync_i.
  - That beat is beat 0 of slot 00 → state RUN, locked=1 from the next cycle.
  - With HOLD=1 that same beat is also captured as A.
- RUN, on each valid beat:
  - If beat==HOLD-1: capture din into the capture register for the current slot, clear beat, slot=slot+1 (mod 4).
  - Otherwise: beat=beat+1.
- Frame output:
  - Completing slot 11 (beat HOLD-1 of D) marks the frame complete.
  - Next cycle: ch_a..ch_d load atomically from the capture registers (D from this beat's din), and frame_valid=1 for exactly that cycle.
  - Latency is 1 cycle from the D capture beat. ch_* hold their values until the next complete frame.
- Slot wrap: slot 11 → 00 with no idle beat. A continuous stream yields one frame per 4*HOLD valid beats.
- sel_s/sel_t are registered copies of the slot counter: {sel_s,sel_t}=slot. They reflect the slot of the next expected beat.
- Expected sync in RUN: sync_i on beat 0 of slot 00 is accepted silently.
- Unexpected sync in RUN: behaviour is set by the feature below.
- Simultaneous frame completion and reset: reset wins.
- The beat counter is ceil(log2(HOLD)) bits, minimum 1.

Optional Feature:
- Macro: TDM_DEMUX4_SYNC_CHECK_EN.
- Defined: sync_i on any RUN beat other than slot 00 beat 0 triggers a resync.
  - Partial capture registers are cleared.
  - That beat becomes beat 0 of slot 00.
  - No frame_valid is produced for the aborted frame.
  - sync_err pulses 1 cycle.
- Undefined: sync_i is ignored while in RUN, and sync_err is tied 0.

Decomposition:
- Package tdm_demux_pkg holds:
  - state enum {IDLE, RUN};
  - slot constants SLOT_A=2'b00, SLOT_B=2'b01, SLOT_C=2'b10, SLOT_D=2'b11;
  - localparam function for the beat counter width.
- One sub-module: tdm_slot_counter.
  - Contains the beat and slot counters.
  - Inputs: advance, restart.
  - Outputs: slot, last_beat, frame_done.
- The top level keeps the FSM, capture registers and output registers.

Test Plan:
- Reset then idle: rst=1 then released, no sync → all outputs 0, locked=0, sel=00.
- Basic frame, HOLD=4, WIDTH=1:
  - Stimulus: sync at beat 0; last-beat values A=1, B=0, C=1, D=1.
  - Response: one cycle after the 16th beat, ch_a..d=1,0,1,1 with frame_valid high for 1 cycle.
- Gapped stream: same data as the basic frame with din_valid low on every other cycle → identical frame, delivered 1 cycle after the 16th valid beat.
- Back-to-back frames: 3 continuous frames → frame_valid every 16 beats; sel sequence 00,01,10,11 repeats with no gap.
- Mid-frame sync: sync asserted at slot 10 beat 2.
  - With feature: sync_err pulses, the frame is dropped, and the next frame_valid comes 16 beats later.
  - Without feature: frame completes normally and sync_err=0.
- Reset mid-frame: rst asserted at slot 01 → outputs clear immediately, locked=0, and no frame_valid after release until a new sync plus 16 beats.
